// File: rtl/ccu_pkg.sv
// ccu_pkg
// Shared configuration for the CCU conflict tracker.
// Contents:
//   ccu_cfg_t      - CCU configuration record (groups, snoop channels,
//                    tracking depth, conflict index width)
//   CcuCfgDefault  - default configuration used as parameter defaults
//   cm_idx_t       - conflict index type derived from the default width
package ccu_pkg;

    localparam int unsigned CmAddrWidthDflt = 12;

    typedef struct packed {
        int unsigned NoGroups;
        int unsigned NoSnoopChans;
        int unsigned MaxSnoopTrans;
        int unsigned CmAddrWidth;
    } ccu_cfg_t;

    localparam ccu_cfg_t CcuCfgDefault = '{
        NoGroups:      2,
        NoSnoopChans:  2,
        MaxSnoopTrans: 8,
        CmAddrWidth:   CmAddrWidthDflt
    };

    typedef logic [CmAddrWidthDflt-1:0] cm_idx_t;

endpackage

// File: rtl/ace_ccu_cm_alloc.sv
// ace_ccu_cm_alloc
// Purely combinational entry allocator. Each requesting channel, in
// channel order, receives the lowest free entry not already handed to
// a lower channel in the same cycle.
// Ports:
//   free  in  NoEntries            free-entry vector (1 = free)
//   req   in  NoChans              per-channel allocation request
//   grant out NoChans x NoEntries  one-hot entry grant per channel
//                                  (all zero if no request or no free entry)
module ace_ccu_cm_alloc #(
    parameter int unsigned NoChans   = 2,
    parameter int unsigned NoEntries = 8
) (
    input  logic [NoEntries-1:0]              free,
    input  logic [NoChans-1:0]                req,
    output logic [NoChans-1:0][NoEntries-1:0] grant
);

    // avail[c] is what remains free after channels 0..c-1 took their pick.
    logic [NoChans:0][NoEntries-1:0] avail;

    assign avail[0] = free;

    generate
        for (genvar gi = 0; gi < NoChans; gi++) begin : g_chan
            logic [NoEntries-1:0] lowest;
            // x & -x isolates the least significant set bit, which is the
            // same pick a trailing-zero count would make.
            assign lowest        = avail[gi] & (~avail[gi] + NoEntries'(1));
            assign grant[gi]     = req[gi] ? lowest : '0;
            assign avail[gi + 1] = avail[gi] & ~grant[gi];
        end
    endgenerate

endmodule

// File: rtl/ace_ccu_conflict_tracker_mc.sv
// ace_ccu_conflict_tracker_mc
// Tracks in-flight snooped cache-line indices from several snoop channels
// and stalls any new snoop whose index collides with an outstanding one,
// with a duplicate in a lower channel, or that would find the table full.
// Entries are freed by strobes on the master-path response ports.
// Ports:
//   clk_i          in   clock
//   rst_ni         in   asynchronous active-low reset
//   snoop_valid_i  in   per-channel snoop valid
//   snoop_ready_i  in   per-channel downstream ready
//   snoop_addr_i   in   per-channel conflict index (flattened)
//   snoop_stall_o  out  per-channel combinational stall
//   x_req_i        in   per-port release strobe
//   x_addr_i       in   per-port released index (flattened)
//   occupancy_o    out  registered count of valid entries
//   full_o         out  registered occupancy_o == MaxSnoopTrans
module ace_ccu_conflict_tracker_mc
    import ccu_pkg::*;
#(
    parameter int unsigned NoSnoopChans  = CcuCfgDefault.NoSnoopChans,
    parameter int unsigned NoRespPorts   = 2 * CcuCfgDefault.NoGroups,
    parameter int unsigned MaxSnoopTrans = CcuCfgDefault.MaxSnoopTrans,
    parameter int unsigned CmAddrWidth   = CcuCfgDefault.CmAddrWidth,
    localparam int unsigned OccWidth     = $clog2(MaxSnoopTrans + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NoSnoopChans-1:0]             snoop_valid_i,
    input  logic [NoSnoopChans-1:0]             snoop_ready_i,
    input  logic [NoSnoopChans*CmAddrWidth-1:0] snoop_addr_i,
    output logic [NoSnoopChans-1:0]             snoop_stall_o,
    input  logic [NoRespPorts-1:0]              x_req_i,
    input  logic [NoRespPorts*CmAddrWidth-1:0]  x_addr_i,
    output logic [OccWidth-1:0]                 occupancy_o,
    output logic                                full_o
);

    logic [MaxSnoopTrans-1:0]                  valid_reg;
    logic [MaxSnoopTrans-1:0]                  valid_next;
    logic [MaxSnoopTrans-1:0][CmAddrWidth-1:0] addr_reg;
    logic [MaxSnoopTrans-1:0][CmAddrWidth-1:0] addr_next;
    logic [OccWidth-1:0]                       occ_reg;
    logic [OccWidth-1:0]                       occ_next;
    logic                                      full_reg;

    logic [NoSnoopChans-1:0]                   accept;
    logic [NoSnoopChans-1:0][MaxSnoopTrans-1:0] grant;
    logic [MaxSnoopTrans-1:0]                  release_vec;
    logic [MaxSnoopTrans-1:0]                  alloc_vec;
    logic [OccWidth-1:0]                       release_cnt;
    logic [OccWidth-1:0]                       alloc_cnt;

    // ------------------------------------------------------------------
    // Stall evaluation. Lookup uses the registered table only, so a
    // release in the same cycle does not unblock a snoop (conservative).
    // Lower channels that are valid and unstalled reserve an entry and
    // claim their index whether or not they are ready, which keeps the
    // stall independent of snoop_ready_i.
    // ------------------------------------------------------------------
    always_comb begin
        logic [NoSnoopChans-1:0] stall_v;
        logic [OccWidth-1:0]     free_cnt;
        logic [OccWidth-1:0]     taken;
        logic                    hit;
        logic                    dup;

        stall_v  = '0;
        free_cnt = '0;
        taken    = '0;
        for (int e = 0; e < MaxSnoopTrans; e++) begin
            if (!valid_reg[e]) free_cnt = free_cnt + OccWidth'(1);
        end
        for (int c = 0; c < NoSnoopChans; c++) begin
            hit = 1'b0;
            dup = 1'b0;
            for (int e = 0; e < MaxSnoopTrans; e++) begin
                if (valid_reg[e] &&
                    addr_reg[e] == snoop_addr_i[c*CmAddrWidth +: CmAddrWidth]) begin
                    hit = 1'b1;
                end
            end
            for (int k = 0; k < c; k++) begin
                if (snoop_valid_i[k] && !stall_v[k] &&
                    snoop_addr_i[k*CmAddrWidth +: CmAddrWidth] ==
                    snoop_addr_i[c*CmAddrWidth +: CmAddrWidth]) begin
                    dup = 1'b1;
                end
            end
            if (snoop_valid_i[c] && (hit || dup || taken >= free_cnt)) begin
                stall_v[c] = 1'b1;
            end
            if (snoop_valid_i[c] && !stall_v[c]) begin
                taken = taken + OccWidth'(1);
            end
        end
        snoop_stall_o = stall_v;
    end

    assign accept = snoop_valid_i & snoop_ready_i & ~snoop_stall_o;

    ace_ccu_cm_alloc #(
        .NoChans   (NoSnoopChans),
        .NoEntries (MaxSnoopTrans)
    ) i_alloc (
        .free  (~valid_reg),
        .req   (accept),
        .grant (grant)
    );

    // ------------------------------------------------------------------
    // Release, allocation and next-state. Allocated entries are free
    // and released entries are valid, so the two sets never overlap.
    // ------------------------------------------------------------------
    always_comb begin
        release_vec = '0;
        alloc_vec   = '0;
        addr_next   = addr_reg;
        release_cnt = '0;
        alloc_cnt   = '0;
        for (int e = 0; e < MaxSnoopTrans; e++) begin
            for (int p = 0; p < NoRespPorts; p++) begin
                if (valid_reg[e] && x_req_i[p] &&
                    x_addr_i[p*CmAddrWidth +: CmAddrWidth] == addr_reg[e]) begin
                    release_vec[e] = 1'b1;
                end
            end
        end
        for (int c = 0; c < NoSnoopChans; c++) begin
            for (int e = 0; e < MaxSnoopTrans; e++) begin
                if (grant[c][e]) begin
                    alloc_vec[e] = 1'b1;
                    addr_next[e] = snoop_addr_i[c*CmAddrWidth +: CmAddrWidth];
                end
            end
        end
        for (int e = 0; e < MaxSnoopTrans; e++) begin
            if (release_vec[e]) release_cnt = release_cnt + OccWidth'(1);
            if (alloc_vec[e])   alloc_cnt   = alloc_cnt + OccWidth'(1);
        end
    end

    assign valid_next = (valid_reg & ~release_vec) | alloc_vec;
    assign occ_next   = occ_reg - release_cnt + alloc_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= '0;
            addr_reg  <= '0;
            occ_reg   <= '0;
            full_reg  <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            addr_reg  <= addr_next;
            occ_reg   <= occ_next;
            full_reg  <= (occ_next == OccWidth'(MaxSnoopTrans));
        end
    end

    assign occupancy_o = occ_reg;
    assign full_o      = full_reg;

endmodule

// File: tb/tb_ace_ccu_conflict_tracker_mc.sv
module tb_ace_ccu_conflict_tracker_mc;

    localparam int NCH  = 2;
    localparam int NP   = 4;
    localparam int MAXT = 8;
    localparam int W    = 12;
    localparam int OW   = $clog2(MAXT + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NCH-1:0]  s_valid;
    logic [NCH-1:0]  s_ready;
    logic [NCH*W-1:0] s_addr;
    logic [NCH-1:0]  s_stall;
    logic [NP-1:0]   x_req;
    logic [NP*W-1:0] x_addr;
    logic [OW-1:0]   occ;
    logic            full;

    int total = 0;
    int bad   = 0;

    // Outstanding indices as a plain set (queue without duplicates).
    logic [W-1:0] model_q[$];
    logic [NCH-1:0] exp_stall;

    always #5 clk = ~clk;

    ace_ccu_conflict_tracker_mc dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .snoop_valid_i (s_valid),
        .snoop_ready_i (s_ready),
        .snoop_addr_i  (s_addr),
        .snoop_stall_o (s_stall),
        .x_req_i       (x_req),
        .x_addr_i      (x_addr),
        .occupancy_o   (occ),
        .full_o        (full)
    );

    // Stall rules applied to the set: index outstanding, claimed by a lower
    // unstalled channel, or no room left after lower unstalled channels.
    function automatic logic [NCH-1:0] model_stall();
        logic [NCH-1:0] st;
        int granted;
        logic busy;
        logic [W-1:0] a;
        st = '0;
        granted = 0;
        for (int c = 0; c < NCH; c++) begin
            if (s_valid[c]) begin
                a = s_addr[c*W +: W];
                busy = 1'b0;
                foreach (model_q[i]) if (model_q[i] == a) busy = 1'b1;
                for (int k = 0; k < c; k++)
                    if (s_valid[k] && !st[k] && s_addr[k*W +: W] == a) busy = 1'b1;
                if (MAXT - model_q.size() - granted <= 0) busy = 1'b1;
                st[c] = busy;
                if (!busy) granted++;
            end
        end
        return st;
    endfunction

    task automatic set_idle();
        s_valid = '0; s_ready = '0; s_addr = '0; x_req = '0; x_addr = '0;
    endtask

    task automatic settle();
        #2;
        exp_stall = model_stall();
    endtask

    // Advance one clock and apply the cycle's releases and acceptances to the set.
    task automatic tick();
        logic [NCH-1:0] acc;
        logic hit;
        acc = s_valid & s_ready & ~model_stall();
        @(posedge clk);
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            hit = 1'b0;
            for (int p = 0; p < NP; p++)
                if (x_req[p] && x_addr[p*W +: W] == model_q[i]) hit = 1'b1;
            if (hit) begin
                $display("txn release addr=%h", model_q[i]);
                model_q.delete(i);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (acc[c]) begin
                $display("txn accept ch=%0d addr=%h", c, s_addr[c*W +: W]);
                model_q.push_back(s_addr[c*W +: W]);
            end
        end
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #3;
        if (s_stall !== 2'b00) begin bad++; $display("FAIL reset_stall got=%b exp=00", s_stall); end
        total++;
        if (occ !== '0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occ); end
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_channel();
        // cycle 1: accept 0x040
        s_valid = 2'b01; s_ready = 2'b01; s_addr[0 +: W] = 12'h040;
        settle();
        if (s_stall !== 2'b00) begin bad++; $display("FAIL single_first got=%b exp=00", s_stall); end
        total++;
        tick();
        if (occ !== OW'(1)) begin bad++; $display("FAIL single_occ1 got=%0d exp=1", occ); end
        total++;
        tick();
        // cycle 3: same index again is stalled
        s_valid = 2'b01; s_ready = 2'b01; s_addr[0 +: W] = 12'h040;
        settle();
        if (s_stall !== 2'b01) begin bad++; $display("FAIL single_dup got=%b exp=01", s_stall); end
        total++;
        tick();
        // cycle 4: release on port 2, lookup still sees the entry
        s_valid = 2'b01; s_ready = 2'b01; s_addr[0 +: W] = 12'h040;
        x_req = 4'b0100; x_addr[2*W +: W] = 12'h040;
        settle();
        if (s_stall !== 2'b01) begin bad++; $display("FAIL single_prerelease got=%b exp=01", s_stall); end
        total++;
        tick();
        if (occ !== OW'(0)) begin bad++; $display("FAIL single_occ0 got=%0d exp=0", occ); end
        total++;
        // cycle 5: unstalled (not ready, so nothing allocated)
        s_valid = 2'b01; s_ready = 2'b00; s_addr[0 +: W] = 12'h040;
        settle();
        if (s_stall !== exp_stall || s_stall !== 2'b00) begin
            bad++; $display("FAIL single_after_release got=%b exp=00", s_stall);
        end
        total++;
        tick();
    endtask

    task automatic test_same_cycle();
        s_valid = 2'b11; s_ready = 2'b11; s_addr = {12'h123, 12'h123};
        settle();
        if (s_stall !== 2'b10) begin bad++; $display("FAIL same_dup got=%b exp=10", s_stall); end
        total++;
        tick();
        if (occ !== OW'(1)) begin bad++; $display("FAIL same_dup_occ got=%0d exp=1", occ); end
        total++;
        x_req = 4'b0001; x_addr[0 +: W] = 12'h123;
        settle();
        tick();
        s_valid = 2'b11; s_ready = 2'b11; s_addr = {12'h124, 12'h123};
        settle();
        if (s_stall !== 2'b00) begin bad++; $display("FAIL same_distinct got=%b exp=00", s_stall); end
        total++;
        tick();
        if (occ !== OW'(2)) begin bad++; $display("FAIL same_distinct_occ got=%0d exp=2", occ); end
        total++;
        x_req = 4'b0011; x_addr = {24'h0, 12'h124, 12'h123};
        settle();
        tick();
        if (occ !== OW'(0)) begin bad++; $display("FAIL same_cleanup_occ got=%0d exp=0", occ); end
        total++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            s_valid = 2'b11; s_ready = 2'b11;
            s_addr = {W'(12'h101 + 2*i), W'(12'h100 + 2*i)};
            settle();
            if (s_stall !== 2'b00) begin bad++; $display("FAIL fill_stall i=%0d got=%b exp=00", i, s_stall); end
            total++;
            tick();
        end
        if (occ !== OW'(MAXT) || full !== 1'b1) begin
            bad++; $display("FAIL full_flag occ=%0d full=%b exp occ=8 full=1", occ, full);
        end
        total++;
        s_valid = 2'b11; s_ready = 2'b11; s_addr = {12'h201, 12'h200};
        settle();
        if (s_stall !== 2'b11) begin bad++; $display("FAIL full_stall got=%b exp=11", s_stall); end
        total++;
        tick();
        s_valid = 2'b01; s_ready = 2'b01; s_addr[0 +: W] = 12'h7FF;
        x_req = 4'b0010; x_addr[1*W +: W] = 12'h100;
        settle();
        if (s_stall !== 2'b01) begin bad++; $display("FAIL full_release_stall got=%b exp=01", s_stall); end
        total++;
        tick();
        if (occ !== OW'(7) || full !== 1'b0) begin
            bad++; $display("FAIL full_release occ=%0d full=%b exp occ=7 full=0", occ, full);
        end
        total++;
        s_valid = 2'b01; s_ready = 2'b01; s_addr[0 +: W] = 12'h7FF;
        settle();
        if (s_stall !== 2'b00) begin bad++; $display("FAIL full_reuse got=%b exp=00", s_stall); end
        total++;
        tick();
        if (occ !== OW'(MAXT) || full !== 1'b1) begin
            bad++; $display("FAIL full_refill occ=%0d full=%b exp occ=8 full=1", occ, full);
        end
        total++;
    endtask

    task automatic test_double_release();
        x_req = 4'b1111; x_addr = {12'h104, 12'h103, 12'h102, 12'h101};
        settle();
        tick();
        x_req = 4'b1111; x_addr = {12'h7FF, 12'h107, 12'h106, 12'h105};
        settle();
        tick();
        if (occ !== OW'(0) || full !== 1'b0) begin
            bad++; $display("FAIL drain occ=%0d full=%b exp occ=0 full=0", occ, full);
        end
        total++;
        s_valid = 2'b11; s_ready = 2'b11; s_addr = {12'h011, 12'h010};
        settle();
        tick();
        x_req = 4'b1001; x_addr = {12'h010, 12'h000, 12'h000, 12'h010};
        settle();
        tick();
        if (occ !== OW'(1)) begin bad++; $display("FAIL double_release occ=%0d exp=1", occ); end
        total++;
        x_req = 4'b0100; x_addr[2*W +: W] = 12'h0AA;
        settle();
        tick();
        if (occ !== OW'(1)) begin bad++; $display("FAIL unknown_release occ=%0d exp=1", occ); end
        total++;
        s_valid = 2'b01; s_addr[0 +: W] = 12'h011;
        settle();
        if (s_stall !== 2'b01) begin bad++; $display("FAIL unknown_kept got=%b exp=01", s_stall); end
        total++;
        x_req = 4'b0001; x_addr[0 +: W] = 12'h011;
        s_valid = 2'b00;
        settle();
        tick();
    endtask

    task automatic test_random();
        int pick;
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < NCH; c++) begin
                s_valid[c] = ($urandom_range(0, 3) != 0);
                s_ready[c] = ($urandom_range(0, 3) != 0);
                s_addr[c*W +: W] = W'(12'h300 + $urandom_range(0, 11));
            end
            for (int p = 0; p < NP; p++) begin
                x_req[p] = ($urandom_range(0, 4) == 0);
                if (model_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    pick = $urandom_range(0, model_q.size() - 1);
                    x_addr[p*W +: W] = model_q[pick];
                end else begin
                    x_addr[p*W +: W] = W'(12'h300 + $urandom_range(0, 11));
                end
            end
            settle();
            if (s_stall !== exp_stall) begin
                bad++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, s_stall, exp_stall);
            end
            total++;
            tick();
            if (occ !== OW'(model_q.size())) begin
                bad++; $display("FAIL rand_occ n=%0d got=%0d exp=%0d", n, occ, model_q.size());
            end
            total++;
            if (full !== (model_q.size() == MAXT)) begin
                bad++; $display("FAIL rand_full n=%0d got=%b exp=%b", n, full, model_q.size() == MAXT);
            end
            total++;
        end
    endtask

    task automatic test_reset_mid();
        // drain whatever the random phase left behind
        while (model_q.size() > 0) begin
            for (int p = 0; p < NP; p++) begin
                x_req[p] = (p < model_q.size());
                x_addr[p*W +: W] = (p < model_q.size()) ? model_q[p] : '0;
            end
            settle();
            tick();
        end
        s_valid = 2'b11; s_ready = 2'b11; s_addr = {12'h501, 12'h500}; settle(); tick();
        s_valid = 2'b11; s_ready = 2'b11; s_addr = {12'h503, 12'h502}; settle(); tick();
        s_valid = 2'b01; s_ready = 2'b01; s_addr[0 +: W] = 12'h504; settle(); tick();
        if (occ !== OW'(5)) begin bad++; $display("FAIL mid_fill occ=%0d exp=5", occ); end
        total++;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        if (occ !== OW'(0) || full !== 1'b0) begin
            bad++; $display("FAIL mid_reset occ=%0d full=%b exp occ=0 full=0", occ, full);
        end
        total++;
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        s_valid = 2'b01; s_ready = 2'b01; s_addr[0 +: W] = 12'h500;
        settle();
        if (s_stall !== 2'b00) begin bad++; $display("FAIL mid_reaccept got=%b exp=00", s_stall); end
        total++;
        tick();
        if (occ !== OW'(1)) begin bad++; $display("FAIL mid_reaccept_occ got=%0d exp=1", occ); end
        total++;
    endtask

    initial begin
        set_idle();
        test_reset();
        test_single_channel();
        test_same_cycle();
        test_full();
        test_double_release();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
